// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the 32-bit ALU.
// Captures decoded operands and control once per clock. It detects load-use
// hazards and inserts a bubble on a stall or a branch flush. It also forwards
// EX/MEM and MEM/WB results so that the ALU sees final operands.
module id_ex_stage #(
   parameter int WIDTH  = 32,
   parameter int RADDR  = 5,
   parameter int FWD_EN = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,          // active-low, asynchronous
   input  logic             i_flush,
   input  logic             i_id_valid,
   input  logic [RADDR-1:0] i_id_rs,
   input  logic [RADDR-1:0] i_id_rt,
   input  logic [RADDR-1:0] i_id_rd,
   input  logic [WIDTH-1:0] i_id_rs_data,
   input  logic [WIDTH-1:0] i_id_rt_data,
   input  logic [WIDTH-1:0] i_id_imm,
   input  logic [3:0]       i_id_alu_control,
   input  logic [4:0]       i_id_shamt,
   input  logic [5:0]       i_id_ctrl,        // {branch, reg_dst, alu_src, mem_write, mem_read, reg_write}
   input  logic             i_exmem_reg_write,
   input  logic [RADDR-1:0] i_exmem_rd,
   input  logic [WIDTH-1:0] i_exmem_result,
   input  logic             i_memwb_reg_write,
   input  logic [RADDR-1:0] i_memwb_rd,
   input  logic [WIDTH-1:0] i_memwb_result,
   output logic             o_stall,
   output logic             o_ex_valid,
   output logic [WIDTH-1:0] o_ex_data1,
   output logic [WIDTH-1:0] o_ex_data2,
   output logic [WIDTH-1:0] o_ex_store_data,
   output logic [3:0]       o_ex_alu_control,
   output logic [4:0]       o_ex_shamt,
   output logic [RADDR-1:0] o_ex_dest,
   output logic [5:0]       o_ex_ctrl
);

   localparam int CTRL_REG_DST  = 4;
   localparam int CTRL_ALU_SRC  = 3;
   localparam int CTRL_MEM_READ = 1;

   // When FWD_EN is 0, both the EX-side forwarding and the decode bypass are
   // disabled. Every operand then comes straight from the register-file read.
   localparam logic FWD_ON = (FWD_EN != 0);

   logic             r_valid;
   logic [5:0]       r_ctrl;
   logic [3:0]       r_alu_control;
   logic [4:0]       r_shamt;
   logic [RADDR-1:0] r_dest;
   logic [RADDR-1:0] r_rs;
   logic [RADDR-1:0] r_rt;
   logic [WIDTH-1:0] r_rs_data;
   logic [WIDTH-1:0] r_rt_data;
   logic [WIDTH-1:0] r_imm;

   logic             w_hazard;
   logic             w_stall;
   logic             w_bubble;
   logic             w_byp_rs;
   logic             w_byp_rt;
   logic [WIDTH-1:0] w_cap_rs_data;
   logic [WIDTH-1:0] w_cap_rt_data;
   logic [RADDR-1:0] w_cap_dest;
   logic             w_exmem_hit_a;
   logic             w_exmem_hit_b;
   logic             w_memwb_hit_a;
   logic             w_memwb_hit_b;
   logic [WIDTH-1:0] w_fwd_a;
   logic [WIDTH-1:0] w_fwd_b;

   // A load in EX whose destination is read by decode must hold decode for
   // one cycle. A flush overrides the stall because that instruction is squashed anyway.
   assign w_hazard = r_valid & r_ctrl[CTRL_MEM_READ] & (r_dest != '0) & i_id_valid &
                     ((r_dest == i_id_rs) | (r_dest == i_id_rt));
   assign w_stall  = i_reset & w_hazard & ~i_flush;
   assign o_stall  = w_stall;
   assign w_bubble = i_flush | w_stall;

   // The decode bypass covers a register-file write and read in the same cycle.
   assign w_byp_rs = FWD_ON & i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_id_rs);
   assign w_byp_rt = FWD_ON & i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_id_rt);
   assign w_cap_rs_data = w_byp_rs ? i_memwb_result : i_id_rs_data;
   assign w_cap_rt_data = w_byp_rt ? i_memwb_result : i_id_rt_data;
   assign w_cap_dest    = i_id_ctrl[CTRL_REG_DST] ? i_id_rd : i_id_rt;

   // Pipeline register: clear on reset, load a bubble on flush or stall, otherwise capture decode.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_valid       <= 1'b0;
         r_ctrl        <= '0;
         r_alu_control <= '0;
         r_shamt       <= '0;
         r_dest        <= '0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_rs_data     <= '0;
         r_rt_data     <= '0;
         r_imm         <= '0;
      end else if (w_bubble) begin
         r_valid       <= 1'b0;
         r_ctrl        <= '0;
         r_alu_control <= '0;
         r_shamt       <= '0;
         r_dest        <= '0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_rs_data     <= '0;
         r_rt_data     <= '0;
         r_imm         <= '0;
      end else begin
         r_valid       <= i_id_valid;
         r_ctrl        <= i_id_ctrl;
         r_alu_control <= i_id_alu_control;
         r_shamt       <= i_id_shamt;
         r_dest        <= w_cap_dest;
         r_rs          <= i_id_rs;
         r_rt          <= i_id_rt;
         r_rs_data     <= w_cap_rs_data;
         r_rt_data     <= w_cap_rt_data;
         r_imm         <= i_id_imm;
      end
   end

   assign w_exmem_hit_a = FWD_ON & i_exmem_reg_write & (i_exmem_rd != '0) & (i_exmem_rd == r_rs);
   assign w_exmem_hit_b = FWD_ON & i_exmem_reg_write & (i_exmem_rd != '0) & (i_exmem_rd == r_rt);
   assign w_memwb_hit_a = FWD_ON & i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == r_rs);
   assign w_memwb_hit_b = FWD_ON & i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == r_rt);

   // Operand forwarding: the younger EX/MEM result takes priority over MEM/WB.
   always_comb begin
      w_fwd_a = r_rs_data;
      w_fwd_b = r_rt_data;
      if (w_exmem_hit_a)      w_fwd_a = i_exmem_result;
      else if (w_memwb_hit_a) w_fwd_a = i_memwb_result;
      if (w_exmem_hit_b)      w_fwd_b = i_exmem_result;
      else if (w_memwb_hit_b) w_fwd_b = i_memwb_result;
   end

   assign o_ex_valid       = r_valid;
   assign o_ex_ctrl        = r_ctrl;
   assign o_ex_alu_control = r_alu_control;
   assign o_ex_shamt       = r_shamt;
   assign o_ex_dest        = r_dest;
   assign o_ex_data1       = w_fwd_a;
   assign o_ex_data2       = r_ctrl[CTRL_ALU_SRC] ? r_imm : w_fwd_b;
   assign o_ex_store_data  = w_fwd_b;

endmodule
